// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the serial deframer (master) and the byte consumer (slave).
interface uart_rx_deframer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 asynchronous serial deframer with a one-byte holding register on a valid/ready
// byte handshake. Define UART_RX_DEFRAMER_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_deframer #(
  parameter int CYCLES_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_rxd,
  uart_rx_deframer_if.master rx,
  output logic               frame_err,
  output logic               overrun
);
  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
`ifdef UART_RX_DEFRAMER_PARITY_EN
    PARITY    = 3'd4,
`endif
    STOP      = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       sync_r;
  logic             rxd_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             deliver_s, fail_s, accept_s;
  logic             rx_valid_r, rx_valid_s;
  logic [7:0]       rx_data_r, rx_data_s;
  logic             frame_err_r, overrun_r, overrun_s;

`ifdef UART_RX_DEFRAMER_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign rxd_s    = sync_r[1];
  assign accept_s = rx_valid_r && rx.rx_ready;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_rxd};
    end
  end

  // Deframer state, bit-time counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= WAIT_HIGH;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
    end
  end

  // Next-state logic; every sample point is a terminal count of cnt.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    deliver_s = 1'b0;
    fail_s    = 1'b0;
    case (state_r)
      WAIT_HIGH: begin
        if (rxd_s) state_s = IDLE;
        else       state_s = WAIT_HIGH;
      end
      IDLE: begin
        if (!rxd_s) begin
          state_s = START;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          idx_s = 3'd0;
          // A start bit that is high again at its midpoint was a glitch.
          if (rxd_s) state_s = IDLE;
          else       state_s = DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s          = '0;
          shift_s[idx_r] = rxd_s;
          if (idx_r == 3'd7) begin
`ifdef UART_RX_DEFRAMER_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_DEFRAMER_PARITY_EN
      PARITY: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = '0;
          if (rxd_s != even_parity(shift_r)) begin
            fail_s  = 1'b1;
            state_s = WAIT_HIGH;
          end else begin
            state_s = STOP;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = '0;
          if (rxd_s) begin
            deliver_s = 1'b1;
            state_s   = IDLE;
          end else begin
            // Low stop bit: wait for the line to return high so a break is one error.
            fail_s  = 1'b1;
            state_s = WAIT_HIGH;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = WAIT_HIGH;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Holding register: a load in the same cycle as an accept replaces the old byte.
  always_comb begin
    rx_valid_s = rx_valid_r;
    rx_data_s  = rx_data_r;
    overrun_s  = 1'b0;
    if (deliver_s) begin
      if (!rx_valid_r || accept_s) begin
        rx_valid_s = 1'b1;
        rx_data_s  = shift_r;
      end else begin
        overrun_s = 1'b1;
      end
    end else if (accept_s) begin
      rx_valid_s = 1'b0;
    end else begin
      rx_valid_s = rx_valid_r;
    end
  end

  // Registered outputs; error pulses last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_r  <= 1'b0;
      rx_data_r   <= 8'h00;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      rx_valid_r  <= rx_valid_s;
      rx_data_r   <= rx_data_s;
      frame_err_r <= fail_s;
      overrun_r   <= overrun_s;
    end
  end

  assign rx.rx_valid = rx_valid_r;
  assign rx.rx_data  = rx_data_r;
  assign frame_err   = frame_err_r;
  assign overrun     = overrun_r;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: frame table, corner-case sequences and
// randomized frames checked cycle by cycle against a frame-level schedule model.
`timescale 1ns/1ps
module tb_uart_rx_deframer;
  localparam int CPB = 16;
`ifdef UART_RX_DEFRAMER_PARITY_EN
  localparam int PAR_EXTRA = CPB;
`else
  localparam int PAR_EXTRA = 0;
`endif
  // Start-bit drive cycle to result edge: 1 to E0, then 2 + CPB/2 + 9*CPB.
  localparam int LAT = 1 + 2 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rxd = 1'b1;
  logic frame_err, overrun;
  int   cyc = 0;

  uart_rx_deframer_if byte_if ();

  uart_rx_deframer #(.CYCLES_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd),
    .rx(byte_if.master), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int ev_kind[int];          // 1 = good byte completes, 2 = frame error
  logic [7:0] ev_byte[int];
  logic m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic p_ready = 1'b0, p_reset = 1'b1, prev_v = 1'b0;
  bit ign_fe = 1'b0, rnd_mode = 1'b0;
  int n_fe = 0, n_ov = 0, n_acc = 0, last_rise = -1, last_start = 0, pulse_cyc = -10;
  logic [7:0] got_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         rdy;      // 0 low, 1 high, 2 one-cycle pulse on the completion edge
    int         gap;      // idle bit times after the frame
    logic       drain;    // one-cycle ready pulse after the gap
    int         acc;
    int         fe;
    int         ov;
    logic [7:0] last_byte;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] last_got();
    if (got_q.size() == 0) return 32'hFFFF_FFFF;
    return {24'h000000, got_q[$]};
  endfunction

  // Holding-register expectations derived from the scheduled frame results.
  task automatic model_step();
    logic acc, efe, eov;
    efe = 1'b0;
    eov = 1'b0;
    acc = m_valid && p_ready;
    if (p_reset) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      ev_kind.delete();
    end else if (ev_kind.exists(cyc)) begin
      if (ev_kind[cyc] == 1) begin
        if (!m_valid || acc) begin
          m_valid = 1'b1;
          m_data  = ev_byte[cyc];
        end else begin
          eov = 1'b1;
        end
      end else begin
        efe = 1'b1;
        if (acc) m_valid = 1'b0;
      end
      ev_kind.delete(cyc);
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (byte_if.rx_valid && byte_if.rx_ready) begin
      n_acc++;
      got_q.push_back(byte_if.rx_data);
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (byte_if.rx_valid && !prev_v) last_rise = cyc;
    prev_v = byte_if.rx_valid;
    if (n_bad < 40) begin
      chk("cyc_valid", byte_if.rx_valid, m_valid);
      if (m_valid) chk("cyc_data", byte_if.rx_data, m_data);
      if (!ign_fe) chk("cyc_frame_err", frame_err, efe);
      chk("cyc_overrun", overrun, eov);
    end
    p_ready = byte_if.rx_ready;
    p_reset = reset;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (cyc == pulse_cyc) byte_if.rx_ready = 1'b1;
    else if (cyc == pulse_cyc + 1) byte_if.rx_ready = 1'b0;
    else if (rnd_mode) byte_if.rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic line(input logic b, input int n);
    uart_rxd = b;
    repeat (n) tick();
  endtask

  task automatic sched(input int t, input int kind, input logic [7:0] d);
    ev_kind[t] = kind;
    ev_byte[t] = d;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pulse_on_done);
    last_start = cyc;
    if (pulse_on_done) pulse_cyc = cyc + LAT + PAR_EXTRA - 1;
    sched(cyc + LAT + PAR_EXTRA, stop_b ? 1 : 2, d);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d[i], CPB);
`ifdef UART_RX_DEFRAMER_PARITY_EN
    line(^d, CPB);
`endif
    line(stop_b, CPB);
  endtask

  initial begin
    int a0, f0, o0, nerr;
    logic [7:0] rd;
    logic rs;
    vt[0] = '{8'hA5, 1'b1, 1, 2, 1'b0, 1, 0, 0, 8'hA5};
    vt[1] = '{8'h3C, 1'b1, 0, 0, 1'b0, 0, 0, 0, 8'hA5};
    vt[2] = '{8'h5A, 1'b1, 0, 2, 1'b1, 1, 0, 1, 8'h3C};
    vt[3] = '{8'h01, 1'b1, 0, 0, 1'b0, 0, 0, 0, 8'h3C};
    vt[4] = '{8'h96, 1'b1, 2, 2, 1'b1, 2, 0, 0, 8'h96};
    vt[5] = '{8'h81, 1'b0, 1, 2, 1'b0, 0, 1, 0, 8'h96};
    vt[6] = '{8'h55, 1'b1, 1, 0, 1'b0, 1, 0, 0, 8'h55};
    vt[7] = '{8'h00, 1'b1, 1, 1, 1'b0, 1, 0, 0, 8'h00};
    byte_if.rx_ready = 1'b0;

    repeat (3) tick();
    chk("reset_valid", byte_if.rx_valid, 1'b0);
    chk("reset_data", byte_if.rx_data, 8'h00);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    reset = 1'b0;
    line(1'b1, 2 * CPB);

    for (int i = 0; i < 8; i++) begin
      a0 = n_acc; f0 = n_fe; o0 = n_ov;
      byte_if.rx_ready = (vt[i].rdy == 1);
      send_frame(vt[i].data, vt[i].stop, vt[i].rdy == 2);
      if (i == 0) chk("first_byte_latency", last_rise, last_start + LAT + PAR_EXTRA);
      line(1'b1, vt[i].gap * CPB);
      if (vt[i].drain) begin
        byte_if.rx_ready = 1'b1;
        tick();
        byte_if.rx_ready = 1'b0;
        tick();
        chk("drain_valid_low", byte_if.rx_valid, 1'b0);
      end
      chk("vec_accepts", n_acc - a0, vt[i].acc);
      chk("vec_frame_errs", n_fe - f0, vt[i].fe);
      chk("vec_overruns", n_ov - o0, vt[i].ov);
      if (vt[i].acc > 0) chk("vec_last_byte", last_got(), {24'h0, vt[i].last_byte});
    end

    // Start-bit glitch, then a real frame.
    byte_if.rx_ready = 1'b1;
    a0 = n_acc; f0 = n_fe;
    line(1'b0, 4);
    line(1'b1, 3 * CPB);
    chk("glitch_no_err", n_fe - f0, 0);
    chk("glitch_no_byte", n_acc - a0, 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    line(1'b1, 2 * CPB);
    chk("after_glitch_count", n_acc - a0, 1);
    chk("after_glitch_byte", last_got(), 32'h7E);

    // Bad stop bit followed by a long break.
    a0 = n_acc; f0 = n_fe;
    send_frame(8'h81, 1'b0, 1'b0);
    line(1'b0, 40 * CPB);
    line(1'b1, 2 * CPB);
    chk("break_one_err", n_fe - f0, 1);
    chk("break_no_byte", n_acc - a0, 0);
    byte_if.rx_ready = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b0);
    line(1'b1, CPB);
    chk("after_break_valid", byte_if.rx_valid, 1'b1);
    chk("after_break_data", byte_if.rx_data, 8'hC3);

    // Reset mid-frame with a byte held and the line low.
    a0 = n_acc;
    line(1'b0, 4 * CPB);
    ign_fe = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    chk("midreset_valid", byte_if.rx_valid, 1'b0);
    chk("midreset_data", byte_if.rx_data, 8'h00);
    chk("midreset_overrun", overrun, 1'b0);
    reset = 1'b0;
    line(1'b0, 12 * CPB);
    chk("midreset_no_byte", n_acc - a0, 0);
    line(1'b1, 2 * CPB);
    ign_fe = 1'b0;
    byte_if.rx_ready = 1'b1;
    send_frame(8'hC3, 1'b1, 1'b0);
    line(1'b1, 2 * CPB);
    chk("after_reset_count", n_acc - a0, 1);
    chk("after_reset_byte", last_got(), 32'hC3);

`ifdef UART_RX_DEFRAMER_PARITY_EN
    // 8'h07 has odd weight, so an even-parity bit of 0 is wrong.
    a0 = n_acc; f0 = n_fe;
    sched(cyc + LAT, 2, 8'h07);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(((8'h07 >> i) & 8'h01) != 8'h00, CPB);
    line(1'b0, CPB);
    line(1'b1, 3 * CPB);
    chk("parity_err", n_fe - f0, 1);
    chk("parity_no_byte", n_acc - a0, 0);
`endif

    // Random frames, random gaps and random back-pressure.
    f0 = n_fe;
    nerr = 0;
    rnd_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      if (!rs) nerr++;
      send_frame(rd, rs, 1'b0);
      line(1'b1, (rs ? $urandom_range(0, 2) : $urandom_range(1, 2)) * CPB);
    end
    rnd_mode = 1'b0;
    byte_if.rx_ready = 1'b1;
    line(1'b1, 2 * CPB);
    chk("random_frame_errs", n_fe - f0, nerr);
    chk("random_drained", byte_if.rx_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial-to-byte receiver that sits directly upstream of the UART probe. It deframes 8N1 asynchronous serial data from a pin into bytes and presents each byte on the probe's `rx_valid`/`rx_data`/`rx_ready` byte handshake. A one-byte holding register absorbs probe back-pressure. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CYCLES_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Integer, must be ≥ 4 and even.
- `clk`, in, 1: sole clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `uart_rxd`, in, 1: asynchronous serial line; idles high.
- `rx_valid`, out, 1: holding register contains a byte.
- `rx_data`, out, 8: held byte; meaningful only while `rx_valid` is high.
- `rx_ready`, in, 1: consumer accepts the byte in any cycle where `rx_valid && rx_ready`.
- `frame_err`, out, 1: one-cycle pulse when a frame fails its checks; the byte is discarded.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- Input synchronizer: two flops, both reset to 1. The FSM sees only the synchronized `rxd_s`.
- FSM states: WAIT_HIGH, IDLE, START, DATA, PARITY (only when the macro is defined), STOP. Each state uses a bit counter `cnt` and a bit index `idx` (0..7).
- WAIT_HIGH: go to IDLE on the first cycle `rxd_s == 1`. This is the reset state.
- IDLE: when `rxd_s == 0`, go to START and clear `cnt`.
- START: when `cnt == CYCLES_PER_BIT/2 - 1`, sample `rxd_s`.
  - If the sample is 1, the start was a glitch: return to IDLE. No error pulse.
  - If the sample is 0, go to DATA with `cnt` and `idx` cleared.
- DATA: when `cnt == CYCLES_PER_BIT - 1`, sample `rxd_s` into shift-register bit `idx` (LSB first) and clear `cnt`.
  - After `idx == 7`, go to STOP (or PARITY when the macro is defined).
- STOP: when `cnt == CYCLES_PER_BIT - 1`, sample `rxd_s`.
  - If the sample is 1, deliver the byte (see below) and go to IDLE.
  - If the sample is 0, pulse `frame_err`, discard the byte and go to WAIT_HIGH. This prevents a break condition from re-triggering frames.
- Delivery, evaluated at the stop-sample edge:
  - Register empty, or `rx_valid && rx_ready` in the same cycle: load `rx_data` and set `rx_valid`. Simultaneous accept and load keeps `rx_valid` high with the new byte.
  - Register full and not accepted: keep the old byte, drop the new one, pulse `overrun`.
- Handshake: while `rx_valid` is high and `rx_ready` is low, `rx_data` and `rx_valid` hold stable. An accept with no load clears `rx_valid` on the next edge.
- Counters wrap only by explicit clear. `cnt` width is `$clog2(CYCLES_PER_BIT)`.

## Timing
- Reset values:
  - Outputs: `rx_valid = 0`, `rx_data = 8'h00`, `frame_err = 0`, `overrun = 0`.
  - Internal: state WAIT_HIGH, synchronizer flops 1, `cnt` 0, `idx` 0.
- Reset mid-frame aborts the frame with no pulse and empties the holding register. Receive resumes only after the line is seen high.
- Let E0 be the edge at which the first synchronizer flop captures the start bit low. Without parity, `rx_valid` is first high after edge E0 + 2 + `CYCLES_PER_BIT`/2 + 9·`CYCLES_PER_BIT`. With parity, add `CYCLES_PER_BIT`.
- `frame_err` and `overrun` are registered and high for exactly one cycle, in the same cycle a good byte would have raised `rx_valid`.
- Back-to-back frames: the FSM is in IDLE from mid-stop-bit onward, so a start bit immediately after the stop bit is received with no gap.
- `rx_ready` has no combinational path to any output.

## Configuration
- `UART_RX_DEFRAMER_PARITY_EN`
  - Defined: frames are 8E1. After DATA, state PARITY samples one more bit at `cnt == CYCLES_PER_BIT - 1`.
    - If the sampled bit differs from `^data`, pulse `frame_err`, discard the byte and go to WAIT_HIGH.
    - Otherwise continue to STOP.
  - Undefined: frames are 8N1, the PARITY state and its logic are absent, and the port list is unchanged.

## Test plan
All scenarios use `CYCLES_PER_BIT = 16`.
- **Basic receive:** hold `rx_ready = 1`, send 8'hA5 → one `rx_valid` pulse with `rx_data = 8'hA5`, exactly at E0 + 2 + 8 + 144 edges.
- **Back-pressure and overrun:** hold `rx_ready = 0`, send 8'h3C then 8'h5A back-to-back → `rx_data` stays 8'h3C and `overrun` pulses once. After raising `rx_ready` for one cycle, `rx_valid` falls.
- **Simultaneous accept and load:** assert `rx_ready` on the cycle the second byte 8'h96 completes while 8'h01 is held → `rx_valid` stays high, `rx_data = 8'h96`, no `overrun`.
- **Glitch rejection:** drive `uart_rxd` low for 4 cycles, then high → no `rx_valid`, no `frame_err`. A following 8'h7E is received correctly.
- **Framing error and break:** send 8'h81 with the stop bit low, then hold the line low for 40 bit times → exactly one `frame_err` pulse and no `rx_valid`. After the line goes high, 8'hC3 is received.
- **Reset and parity:**
  - Assert `reset` mid-data with the line low → outputs are zero, and no byte is delivered until the line returns high.
  - With `UART_RX_DEFRAMER_PARITY_EN` defined, send 8'h07 with parity bit 0 → one `frame_err` pulse and no `rx_valid`.
